// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined mul/div ALU: opcodes, FSM states, default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_SLT   = 4'b1110;
  localparam logic [3:0] OP_ZERO  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

  // MULT, MULTU, DIV and DIVU share the 10xx code space; bit 1 selects divide, bit 0 unsigned.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: magnitude conversion, WIDTH shift-add or
// restoring-subtract iterations, then one sign fix-up cycle presenting HI/LO.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_go,
  input  logic             i_div,
  input  logic             i_unsigned,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  md_state_e          r_state, w_next;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m;
  logic               r_div, r_neg_lo, r_neg_hi;

  logic               w_sa, w_sb, w_b_zero;
  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [WIDTH-1:0]   w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod;

  // Operand signs and magnitudes at the accepting edge; unsigned ops never negate.
  always_comb begin
    w_sa     = ~i_unsigned & i_a[WIDTH-1];
    w_sb     = ~i_unsigned & i_b[WIDTH-1];
    w_ma     = w_sa ? -i_a : i_a;
    w_mb     = w_sb ? -i_b : i_b;
    w_b_zero = (i_b == '0);
  end

  // Next-state: divide by zero skips the iterations and goes straight to FIXUP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_go) w_next = (i_div && w_b_zero) ? FIXUP : RUN;
      RUN:     if (r_cnt == SHW'(WIDTH - 1)) w_next = FIXUP;
      FIXUP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // One iteration step: shift-add into {hi,lo} for multiply, restoring subtract for divide.
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_shift   = {r_hi, r_lo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_m};
    w_step_hi = w_sum[WIDTH:1];
    w_step_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      // The partial remainder is always below 2*divisor, so bit WIDTH of the difference is its sign.
      if (!w_diff[WIDTH]) begin
        w_step_hi = w_diff[WIDTH-1:0];
        w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_shift[WIDTH-1:0];
        w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Iteration datapath: load magnitudes on go, step once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_go) begin
            r_cnt <= '0;
            r_div <= i_div;
            if (i_div && w_b_zero) begin
              // Preload the architectural divide-by-zero answer; fix-up passes it through.
              r_hi     <= i_a;
              r_lo     <= '1;
              r_m      <= '0;
              r_neg_lo <= 1'b0;
              r_neg_hi <= 1'b0;
            end else if (i_div) begin
              r_hi     <= '0;
              r_lo     <= w_ma;
              r_m      <= w_mb;
              r_neg_lo <= w_sa ^ w_sb;
              r_neg_hi <= w_sa;
            end else begin
              r_hi     <= '0;
              r_lo     <= w_mb;
              r_m      <= w_ma;
              r_neg_lo <= w_sa ^ w_sb;
              r_neg_hi <= w_sa ^ w_sb;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up: the product negates as one double-width value, quotient and remainder separately.
  // Most-negative / -1 needs no special case: its magnitude quotient already reads back as most-negative.
  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg_lo) w_prod = -w_prod;
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      o_hi = r_neg_hi ? -r_hi : r_hi;
      o_lo = r_neg_lo ? -r_lo : r_lo;
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_valid = (r_state == FIXUP);

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// multiply/divide into architectural HI/LO, with a start/Busy/Done handshake.
module pipelined_muldiv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [WIDTH-1:0]        r_result, r_hi, r_lo;
  logic                    r_zero, r_done;

  logic                    w_accept, w_is_md, w_md_go;
  logic                    w_md_busy, w_md_valid;
  logic [WIDTH-1:0]        w_md_hi, w_md_lo;
  logic [WIDTH-1:0]        w_alu;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;

  assign w_accept = start & ~w_md_busy;
  assign w_is_md  = is_muldiv(ALUOperation);
  assign w_md_go  = w_accept & w_is_md;
  assign w_a_s    = A;
  assign w_b_s    = B;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .i_go       (w_md_go),
    .i_div      (ALUOperation[1]),
    .i_unsigned (ALUOperation[0]),
    .i_a        (A),
    .i_b        (B),
    .o_busy     (w_md_busy),
    .o_valid    (w_md_valid),
    .o_hi       (w_md_hi),
    .o_lo       (w_md_lo)
  );

  // Single-cycle result selection; MFHI/MFLO read the architectural registers.
  always_comb begin
    w_alu = '0;
    case (ALUOperation)
      OP_AND:  w_alu = A & B;
      OP_OR:   w_alu = A | B;
      OP_NOR:  w_alu = ~(A | B);
      OP_ADD:  w_alu = A + B;
      OP_SUB:  w_alu = A - B;
      OP_SLL:  w_alu = B << Shamt;
      OP_SRL:  w_alu = B >> Shamt;
      OP_LUI:  w_alu = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      default: w_alu = '0;
    endcase
  end

  // Result/Zero/Done/HI/LO registers: engine completion or an accepted single-cycle op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_md_valid) begin
        r_hi     <= w_md_hi;
        r_lo     <= w_md_lo;
        r_result <= w_md_lo;
        r_zero   <= (w_md_lo == '0);
        r_done   <= 1'b1;
      end else if (w_accept && !w_is_md) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        r_done   <= 1'b1;
      end
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Busy      = w_md_busy;
  assign Done      = r_done;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Scoreboard bench for pipelined_muldiv_alu at WIDTH=32.
module tb_pipelined_muldiv_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    ALUOperation;
  logic [W-1:0]  A, B;
  logic [4:0]    Shamt;
  logic [W-1:0]  ALUResult, HI, LO;
  logic          Zero, Busy, Done;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi, m_lo;
  int           n_chk  = 0;
  int           n_fail = 0;

  pipelined_muldiv_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .Shamt        (Shamt),
    .ALUResult    (ALUResult),
    .Zero         (Zero),
    .Busy         (Busy),
    .Done         (Done),
    .HI           (HI),
    .LO           (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain SV arithmetic, tracks architectural HI/LO at issue time.
  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh);
    exp_t        e;
    logic [63:0] p;
    int          qs, rs;
    e.res = '0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = ~(a | b);
      4'd3:  e.res = a + b;
      4'd4:  e.res = a - b;
      4'd5:  e.res = b << sh;
      4'd6:  e.res = b >> sh;
      4'd7:  e.res = {b[15:0], 16'h0000};
      4'd8: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd9: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      4'd10: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_hi = '0; m_lo = 32'h80000000;
        end else begin
          qs = $signed(a) / $signed(b);
          rs = $signed(a) % $signed(b);
          m_lo = qs; m_hi = rs;
        end
      end
      4'd11: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      4'd12: e.res = m_hi;
      4'd13: e.res = m_lo;
      4'd14: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    if (op[3:2] == 2'b10) e.res = m_lo;
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);
  endtask

  // Scoreboard pop on every Done pulse.
  always @(negedge clk) begin
    if (Done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_result", ALUResult, e.res);
        chk("sb_zero", {31'd0, Zero}, {31'd0, (e.res == 0)});
        chk("sb_hi", HI, e.hi);
        chk("sb_lo", LO, e.lo);
      end
    end
  end

  // Issue one op at a negedge, then count negedges until Done and Busy cycles seen.
  // When intrude is set, a MULTU start is raised so that it lands on edge E0+5.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input bit intrude, input string tag);
    int n, busy_c, exp_n, exp_busy;
    bit seen;
    if (op[3:2] == 2'b10) begin
      if (op[1] && b == 0) begin exp_n = 2;     exp_busy = 1;     end
      else                 begin exp_n = W + 2; exp_busy = W + 1; end
    end else begin
      exp_n = 1; exp_busy = 0;
    end
    start = 1'b1; ALUOperation = op; A = a; B = b; Shamt = sh;
    push_exp(op, a, b, sh);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; busy_c = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (Busy) busy_c++;
      if (Done) seen = 1'b1;
      if (intrude && n == 5) begin
        start = 1'b1; ALUOperation = 4'd9; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      end else if (intrude && n == 6) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_negedges"}, n, exp_n);
    chk({tag, "_busy_cycles"}, busy_c, exp_busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ALUOperation = '0; A = '0; B = '0; Shamt = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", ALUResult, 32'h0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single-cycle ops, back to back.
    run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, "add");
    chk("add_ovf", ALUResult, 32'h8000_0000);
    chk("add_zero", {31'd0, Zero}, 32'd0);
    run_op(4'd4, 32'd5, 32'd5, 5'd0, 1'b0, "sub");
    chk("sub_zero", {31'd0, Zero}, 32'd1);
    run_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b0, "and");
    run_op(4'd1, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0, "or");
    run_op(4'd2, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0, "nor");
    run_op(4'd5, 32'h0, 32'h8000_0001, 5'd31, 1'b0, "sll");
    run_op(4'd6, 32'h0, 32'h8000_0001, 5'd31, 1'b0, "srl");
    run_op(4'd7, 32'h0, 32'hABCD_1234, 5'd0, 1'b0, "lui");
    run_op(4'd14, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0, "slt_neg");
    run_op(4'd14, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, "slt_pos");
    run_op(4'd15, 32'h1234, 32'h5678, 5'd0, 1'b0, "op_zero");

    // MULT -3 * 7, then a quiet cycle: Done drops, outputs hold.
    run_op(4'd8, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0, "mult");
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFEB);
    chk("mult_res", ALUResult, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("mult_done_pulse", {31'd0, Done}, 32'd0);
    chk("mult_hold_res", ALUResult, 32'hFFFF_FFEB);
    chk("mult_hold_hi", HI, 32'hFFFF_FFFF);

    run_op(4'd10, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, "div");
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd11, 32'h8000_0000, 32'h10, 5'd0, 1'b0, "divu");
    chk("divu_lo", LO, 32'h0800_0000);
    chk("divu_hi", HI, 32'h0);
    run_op(4'd11, 32'h1234, 32'h0, 5'd0, 1'b0, "divu_zero");
    chk("dz_hi", HI, 32'h1234);
    chk("dz_lo", LO, 32'hFFFF_FFFF);
    run_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, "div_ovf");
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0);
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, "multu");

    // MULTU raised while a DIV is busy is dropped; MFLO in the Done cycle sees the new LO.
    run_op(4'd10, 32'd100, 32'hFFFF_FFF9, 5'd0, 1'b1, "div_busy");
    run_op(4'd13, 32'h0, 32'h0, 5'd0, 1'b0, "mflo_b2b");
    chk("mflo_b2b_val", ALUResult, 32'hFFFF_FFF2);
    run_op(4'd12, 32'h0, 32'h0, 5'd0, 1'b0, "mfhi");

    // A few random ops through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      run_op(rop, $urandom, (i == 3) ? 32'h0 : $urandom, 5'($urandom_range(0, 31)), 1'b0, "rand");
    end

    // Reset at iteration 10 of a MULT, with a competing start on the same edge.
    run_op(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0, "pre_rst");
    start = 1'b1; ALUOperation = 4'd8; A = 32'h7654_3210; B = 32'h0FED_CBA9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; ALUOperation = 4'd3; A = 32'h1; B = 32'h1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("mrst_result", ALUResult, 32'h0);
    chk("mrst_zero", {31'd0, Zero}, 32'd1);
    chk("mrst_busy", {31'd0, Busy}, 32'd0);
    chk("mrst_done", {31'd0, Done}, 32'd0);
    chk("mrst_hi", HI, 32'h0);
    chk("mrst_lo", LO, 32'h0);
    repeat (40) @(negedge clk);
    chk("mrst_no_late_done", {31'd0, Done}, 32'd0);
    chk("mrst_lo_quiet", LO, 32'h0);
    run_op(4'd12, 32'h5, 32'h6, 5'd0, 1'b0, "mfhi_after_rst");
    chk("mfhi_rst_res", ALUResult, 32'h0);
    chk("mfhi_rst_zero", {31'd0, Zero}, 32'd1);

    @(negedge clk);
    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
